rat_maze_ctrl: RTL and testbench

Control FSM for the rat-in-maze solver. Sequences the maze datapath (position registers, maze/visited memory, path stack) through a depth-first search from the start cell to the goal cell, then replays the found path on request as one `move` pulse per step. The block holds only the FSM, a direction-try counter, a stack-depth counter and a replay index. All storage and address arithmetic stay in the datapath.

---
 rtl/rat_maze_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_rat_maze_ctrl.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rat_maze_ctrl.sv
// Depth-first search sequencer for the rat-in-maze datapath, with on-request path replay.
// Latency: one cycle per FSM step; 2 cycles per probed direction or backtrack, 1 per oob skip.
// Backpressure: none; start/run are sampled only in their accepting states, ignored elsewhere.
module rat_maze_ctrl #(
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               run,
    input  logic               at_goal,
    input  logic               oob,
    input  logic               cell_blocked,
    input  logic [1:0]         pop_dir,
    output logic               init_dp,
    output logic [1:0]         dir,
    output logic               rd_en,
    output logic               adv,
    output logic               pop,
    output logic [DEPTH_W-1:0] replay_idx,
    output logic               move,
    output logic               done,
    output logic               fail
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_CHECK,
        S_WAIT,
        S_BACK,
        S_RESTORE,
        S_DONE,
        S_FAIL,
        S_REPLAY
    } state_t;

    // Deepest stack the datapath can hold; one more advance would overflow it.
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
    localparam logic [2:0]         TRY_DONE  = 3'd4;

    state_t             state;
    state_t             state_d;
    logic [2:0]         try_q;
    logic [2:0]         try_d;
    logic [DEPTH_W-1:0] depth;
    logic [DEPTH_W-1:0] depth_d;
    logic [DEPTH_W-1:0] replay_idx_d;

    // The candidate direction is the low two bits of the try counter; try == 4 means all exhausted.
    assign dir = try_q[1:0];

    // State, try counter, stack depth and replay index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            try_q      <= 3'd0;
            depth      <= '0;
            replay_idx <= '0;
        end else begin
            state      <= state_d;
            try_q      <= try_d;
            depth      <= depth_d;
            replay_idx <= replay_idx_d;
        end
    end

    // Next-state and datapath strobes; every strobe is a decode of the current state and inputs.
    always_comb begin
        state_d      = state;
        try_d        = try_q;
        depth_d      = depth;
        replay_idx_d = replay_idx;
        init_dp      = 1'b0;
        rd_en        = 1'b0;
        adv          = 1'b0;
        pop          = 1'b0;
        move         = 1'b0;
        done         = 1'b0;
        fail         = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                end
            end

            S_INIT: begin
                init_dp = 1'b1;
                try_d   = 3'd0;
                depth_d = '0;
                state_d = S_CHECK;
            end

            S_CHECK: begin
                if (at_goal) begin
                    state_d = S_DONE;
                end else if (try_q == TRY_DONE) begin
                    state_d = S_BACK;
                end else if (oob) begin
                    // Off-grid neighbour: skip it without spending a memory read.
                    try_d = try_q + 3'd1;
                end else begin
                    rd_en   = 1'b1;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (cell_blocked) begin
                    try_d   = try_q + 3'd1;
                    state_d = S_CHECK;
                end else if (depth == DEPTH_MAX) begin
                    // Pushing now would overflow the path stack; give up instead.
                    state_d = S_FAIL;
                end else begin
                    adv     = 1'b1;
                    depth_d = depth + DEPTH_ONE;
                    try_d   = 3'd0;
                    state_d = S_CHECK;
                end
            end

            S_BACK: begin
                if (depth == '0) begin
                    // Exhausted every direction at the start cell: no path exists.
                    state_d = S_FAIL;
                end else begin
                    pop     = 1'b1;
                    depth_d = depth - DEPTH_ONE;
                    state_d = S_RESTORE;
                end
            end

            S_RESTORE: begin
                // Resume at the direction after the one that led into the dead end.
                try_d   = {1'b0, pop_dir} + 3'd1;
                state_d = S_CHECK;
            end

            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d = S_INIT;
                end else if (run) begin
                    replay_idx_d = '0;
                    state_d      = S_REPLAY;
                end
            end

            S_REPLAY: begin
                done = 1'b1;
                if (depth == '0) begin
                    state_d = S_DONE;
                end else begin
                    move = 1'b1;
                    if (replay_idx == depth - DEPTH_ONE) begin
                        state_d = S_DONE;
                    end else begin
                        replay_idx_d = replay_idx + DEPTH_ONE;
                    end
                end
            end

            S_FAIL: begin
                fail = 1'b1;
                if (start) begin
                    state_d = S_INIT;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rat_maze_ctrl.sv
// Self-checking bench: behavioural maze datapath around two controllers (deep and shallow stack).
// Latency: checks sampled on the falling edge, half a cycle after each state update.
// Backpressure: none; start/run pulses are driven for exactly one rising edge.
module tb_rat_maze_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] start;
    logic [1:0] run;
    logic [1:0] at_goal;
    logic [1:0] oob;
    logic [1:0] cell_blocked = 2'b00;
    logic [1:0] pop_dir [2] = '{2'd0, 2'd0};
    logic [1:0] init_dp;
    logic [1:0] dir [2];
    logic [1:0] rd_en;
    logic [1:0] adv;
    logic [1:0] pop;
    logic [1:0] move;
    logic [1:0] done;
    logic [1:0] fail;
    logic [7:0] ridx0;
    logic [1:0] ridx1;

    rat_maze_ctrl #(.DEPTH_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .run(run[0]),
        .at_goal(at_goal[0]), .oob(oob[0]), .cell_blocked(cell_blocked[0]), .pop_dir(pop_dir[0]),
        .init_dp(init_dp[0]), .dir(dir[0]), .rd_en(rd_en[0]), .adv(adv[0]), .pop(pop[0]),
        .replay_idx(ridx0), .move(move[0]), .done(done[0]), .fail(fail[0])
    );

    rat_maze_ctrl #(.DEPTH_W(2)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .run(run[1]),
        .at_goal(at_goal[1]), .oob(oob[1]), .cell_blocked(cell_blocked[1]), .pop_dir(pop_dir[1]),
        .init_dp(init_dp[1]), .dir(dir[1]), .rd_en(rd_en[1]), .adv(adv[1]), .pop(pop[1]),
        .replay_idx(ridx1), .move(move[1]), .done(done[1]), .fail(fail[1])
    );

    // Maze description per instance (written by the tests) and datapath state (written by the model).
    int   rows [2];
    int   cols [2];
    int   gr [2];
    int   gc [2];
    bit   wall [2][8][8];
    bit   visited [2][8][8];
    int   pr [2] = '{0, 0};
    int   pc [2] = '{0, 0};
    int   sp [2] = '{0, 0};
    int   stk_r [2][64];
    int   stk_c [2][64];
    logic [1:0] stk_d [2][64];

    int checks = 0;
    int errors = 0;
    int exp_adv [$];
    int exp_idx [$];

    function automatic int nb_r(input int r, input logic [1:0] d);
        if (d == 2'd1) return r + 1;
        if (d == 2'd3) return r - 1;
        return r;
    endfunction

    function automatic int nb_c(input int c, input logic [1:0] d);
        if (d == 2'd0) return c + 1;
        if (d == 2'd2) return c - 1;
        return c;
    endfunction

    function automatic logic is_oob(input int r, input int c, input int nrows, input int ncols);
        return (r < 0) || (r >= nrows) || (c < 0) || (c >= ncols);
    endfunction

    // Combinational datapath flags.
    always_comb begin
        at_goal = 2'b00;
        oob     = 2'b00;
        for (int k = 0; k < 2; k++) begin
            at_goal[k] = (pr[k] == gr[k]) && (pc[k] == gc[k]);
            oob[k]     = is_oob(nb_r(pr[k], dir[k]), nb_c(pc[k], dir[k]), rows[k], cols[k]);
        end
    end

    // Behavioural datapath: visited map, position and path stack.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (init_dp[k]) begin
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++)
                        visited[k][r][c] <= 1'b0;
                visited[k][0][0] <= 1'b1;
                pr[k] <= 0;
                pc[k] <= 0;
                sp[k] <= 0;
            end else begin
                if (rd_en[k])
                    cell_blocked[k] <= wall[k][nb_r(pr[k], dir[k])][nb_c(pc[k], dir[k])] |
                                       visited[k][nb_r(pr[k], dir[k])][nb_c(pc[k], dir[k])];
                if (adv[k]) begin
                    stk_r[k][sp[k]] <= pr[k];
                    stk_c[k][sp[k]] <= pc[k];
                    stk_d[k][sp[k]] <= dir[k];
                    sp[k] <= sp[k] + 1;
                    pr[k] <= nb_r(pr[k], dir[k]);
                    pc[k] <= nb_c(pc[k], dir[k]);
                    visited[k][nb_r(pr[k], dir[k])][nb_c(pc[k], dir[k])] <= 1'b1;
                end
                if (pop[k] && sp[k] > 0) begin
                    pr[k]      <= stk_r[k][sp[k] - 1];
                    pc[k]      <= stk_c[k][sp[k] - 1];
                    pop_dir[k] <= stk_d[k][sp[k] - 1];
                    sp[k]      <= sp[k] - 1;
                end
            end
        end
    end

    task automatic set_maze(input int k, input int r, input int c, input int g_r, input int g_c);
        rows[k] = r;
        cols[k] = c;
        gr[k]   = g_r;
        gc[k]   = g_c;
        for (int rr = 0; rr < 8; rr++)
            for (int cc = 0; cc < 8; cc++)
                wall[k][rr][cc] = 1'b0;
    endtask

    // Pulse start, then watch until done/fail; every adv is scored against exp_adv (r*8+c of new cell).
    task automatic do_search(input int k, input int budget, input bit poke,
                             output int end_iter, output int n_adv, output int n_pop,
                             output int n_init, output int dir_after_pop);
        int  pop_age;
        int  got;
        int  want;
        bit  poked;
        pop_age       = -1;
        poked         = 1'b0;
        end_iter      = 0;
        n_adv         = 0;
        n_pop         = 0;
        n_init        = 0;
        dir_after_pop = -1;
        @(negedge clk);
        start[k] = 1'b1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            start[k] = 1'b0;
            if (init_dp[k]) n_init++;
            if (pop_age >= 0) begin
                pop_age++;
                if (pop_age == 2 && dir_after_pop < 0) dir_after_pop = int'(dir[k]);
            end
            if (pop[k]) begin
                n_pop++;
                if (pop_age < 0) pop_age = 0;
            end
            if (adv[k]) begin
                n_adv++;
                got = nb_r(pr[k], dir[k]) * 8 + nb_c(pc[k], dir[k]);
                checks++;
                if (exp_adv.size() == 0) begin
                    errors++;
                    $display("FAIL adv_unexpected: inst %0d advanced to cell %0d, none expected", k, got);
                end else begin
                    want = exp_adv.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL adv_cell: inst %0d got cell %0d expected %0d", k, got, want);
                    end
                end
            end
            if (poke && !poked && rd_en[k]) begin
                start[k] = 1'b1;
                poked    = 1'b1;
            end
            if (done[k] || fail[k]) begin
                end_iter = i;
                break;
            end
        end
        start[k] = 1'b0;
        checks++;
        if (end_iter == 0) begin
            errors++;
            $display("FAIL search_timeout: inst %0d no done/fail within %0d cycles", k, budget);
        end
        checks++;
        if (exp_adv.size() != 0) begin
            errors++;
            $display("FAIL adv_missing: inst %0d got %0d advances, %0d expected ones never seen",
                     k, n_adv, exp_adv.size());
        end
        exp_adv.delete();
    endtask

    task automatic test_reset();
        logic [16:0] v0;
        logic [10:0] v1;
        bit          moved;
        rst   = 1'b1;
        start = 2'b00;
        run   = 2'b00;
        #1;
        v0 = {init_dp[0], rd_en[0], adv[0], pop[0], move[0], done[0], fail[0], dir[0], ridx0};
        v1 = {init_dp[1], rd_en[1], adv[1], pop[1], move[1], done[1], fail[1], dir[1], ridx1};
        checks++;
        if (v0 !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs0: got %h expected 0", v0);
        end
        checks++;
        if (v1 !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs1: got %h expected 0", v1);
        end
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        moved = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (init_dp !== 2'b00 || done !== 2'b00 || fail !== 2'b00 || rd_en !== 2'b00) moved = 1'b1;
        end
        checks++;
        if (moved) begin
            errors++;
            $display("FAIL idle_without_start: got activity 1 expected 0");
        end
    endtask

    task automatic test_corridor();
        int e, na, np, ni, dp;
        set_maze(0, 1, 4, 0, 3);
        exp_adv = '{1, 2, 3};
        do_search(0, 40, 1'b0, e, na, np, ni, dp);
        checks++;
        if (e !== 9) begin errors++; $display("FAIL corridor_latency: got %0d expected 9", e); end
        checks++;
        if (done[0] !== 1'b1 || fail[0] !== 1'b0) begin
            errors++;
            $display("FAIL corridor_result: got done=%b fail=%b expected done=1 fail=0", done[0], fail[0]);
        end
        checks++;
        if (na !== 3 || np !== 0) begin
            errors++;
            $display("FAIL corridor_counts: got adv=%0d pop=%0d expected adv=3 pop=0", na, np);
        end
        checks++;
        if (sp[0] !== 3) begin errors++; $display("FAIL corridor_depth: got %0d expected 3", sp[0]); end
    endtask

    task automatic run_replay(input int pass, input int d);
        int  n_move, first, last, want;
        bit  dropped;
        n_move  = 0;
        first   = 0;
        last    = 0;
        dropped = 1'b0;
        for (int j = 0; j < d; j++) exp_idx.push_back(j);
        @(negedge clk);
        run[0] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            run[0] = 1'b0;
            if (!done[0]) dropped = 1'b1;
            if (move[0]) begin
                n_move++;
                if (first == 0) first = i;
                last = i;
                checks++;
                if (exp_idx.size() == 0) begin
                    errors++;
                    $display("FAIL replay_extra_move: pass %0d idx %0d", pass, ridx0);
                end else begin
                    want = exp_idx.pop_front();
                    if (int'(ridx0) !== want) begin
                        errors++;
                        $display("FAIL replay_idx: pass %0d got %0d expected %0d", pass, ridx0, want);
                    end
                end
            end
        end
        checks++;
        if (n_move !== d || first !== 1 || last !== d) begin
            errors++;
            $display("FAIL replay_window: pass %0d got moves=%0d first=%0d last=%0d expected %0d,1,%0d",
                     pass, n_move, first, last, d, d);
        end
        checks++;
        if (dropped) begin errors++; $display("FAIL replay_done_held: pass %0d got drop 1 expected 0", pass); end
        exp_idx.delete();
    endtask

    task automatic test_replay();
        int e, na, np, ni, dp;
        set_maze(0, 1, 6, 0, 5);
        exp_adv = '{1, 2, 3, 4, 5};
        do_search(0, 40, 1'b0, e, na, np, ni, dp);
        checks++;
        if (done[0] !== 1'b1) begin errors++; $display("FAIL replay_setup_done: got %b expected 1", done[0]); end
        run_replay(0, 5);
        run_replay(1, 5);
    endtask

    task automatic test_backtrack();
        int e, na, np, ni, dp;
        set_maze(0, 3, 3, 2, 1);
        wall[0][0][2] = 1'b1;
        wall[0][1][1] = 1'b1;
        exp_adv = '{1, 8, 16, 17};
        do_search(0, 80, 1'b0, e, na, np, ni, dp);
        checks++;
        if (np !== 1) begin errors++; $display("FAIL backtrack_pops: got %0d expected 1", np); end
        checks++;
        if (dp !== 1) begin errors++; $display("FAIL backtrack_restore_dir: got %0d expected 1", dp); end
        checks++;
        if (done[0] !== 1'b1 || fail[0] !== 1'b0) begin
            errors++;
            $display("FAIL backtrack_result: got done=%b fail=%b expected 1 0", done[0], fail[0]);
        end
        checks++;
        if (sp[0] !== 3) begin errors++; $display("FAIL backtrack_depth: got %0d expected 3", sp[0]); end
    endtask

    task automatic test_enclosed();
        int e, na, np, ni, dp;
        set_maze(0, 3, 3, 2, 2);
        wall[0][0][1] = 1'b1;
        wall[0][1][0] = 1'b1;
        exp_adv.delete();
        do_search(0, 40, 1'b0, e, na, np, ni, dp);
        checks++;
        if (fail[0] !== 1'b1 || done[0] !== 1'b0) begin
            errors++;
            $display("FAIL enclosed_result: got fail=%b done=%b expected 1 0", fail[0], done[0]);
        end
        checks++;
        if (e !== 10) begin errors++; $display("FAIL enclosed_latency: got %0d expected 10", e); end
        checks++;
        if (na !== 0 || np !== 0) begin
            errors++;
            $display("FAIL enclosed_counts: got adv=%0d pop=%0d expected 0 0", na, np);
        end
    endtask

    task automatic test_overflow();
        int e, na, np, ni, dp;
        set_maze(1, 2, 3, 1, 1);
        exp_adv = '{1, 2, 10};
        do_search(1, 40, 1'b0, e, na, np, ni, dp);
        checks++;
        if (fail[1] !== 1'b1 || done[1] !== 1'b0) begin
            errors++;
            $display("FAIL overflow_result: got fail=%b done=%b expected 1 0", fail[1], done[1]);
        end
        checks++;
        if (na !== 3 || sp[1] !== 3) begin
            errors++;
            $display("FAIL overflow_depth: got adv=%0d depth=%0d expected 3 3", na, sp[1]);
        end
    endtask

    task automatic test_ignore_start();
        int e, na, np, ni, dp;
        set_maze(0, 1, 4, 0, 3);
        exp_adv = '{1, 2, 3};
        do_search(0, 40, 1'b1, e, na, np, ni, dp);
        checks++;
        if (ni !== 1) begin errors++; $display("FAIL ignore_start_inits: got %0d expected 1", ni); end
        checks++;
        if (e !== 9 || done[0] !== 1'b1) begin
            errors++;
            $display("FAIL ignore_start_result: got latency=%0d done=%b expected 9 1", e, done[0]);
        end
    endtask

    task automatic test_done_priority();
        int  e, na, np, ni, dp;
        bit  finished;
        set_maze(0, 1, 4, 0, 3);
        exp_adv = '{1, 2, 3};
        do_search(0, 40, 1'b0, e, na, np, ni, dp);
        @(negedge clk);
        start[0] = 1'b1;
        run[0]   = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        run[0]   = 1'b0;
        checks++;
        if (init_dp[0] !== 1'b1 || move[0] !== 1'b0 || done[0] !== 1'b0) begin
            errors++;
            $display("FAIL start_over_run: got init=%b move=%b done=%b expected 1 0 0",
                     init_dp[0], move[0], done[0]);
        end
        finished = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done[0]) begin
                finished = 1'b1;
                break;
            end
        end
        checks++;
        if (!finished || sp[0] !== 3) begin
            errors++;
            $display("FAIL restart_search: got finished=%b depth=%0d expected 1 3", finished, sp[0]);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [16:0] v0;
        logic [10:0] v1;
        bit          seen;
        bit          moved;
        set_maze(0, 1, 4, 0, 3);
        seen = 1'b0;
        @(negedge clk);
        start[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start[0] = 1'b0;
            if (rd_en[0]) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (!seen || adv[0] !== 1'b1) begin
            errors++;
            $display("FAIL wait_precondition: got rd_seen=%b adv=%b expected 1 1", seen, adv[0]);
        end
        rst = 1'b1;
        #1;
        v0 = {init_dp[0], rd_en[0], adv[0], pop[0], move[0], done[0], fail[0], dir[0], ridx0};
        v1 = {init_dp[1], rd_en[1], adv[1], pop[1], move[1], done[1], fail[1], dir[1], ridx1};
        checks++;
        if (v0 !== 17'd0) begin errors++; $display("FAIL async_reset0: got %h expected 0", v0); end
        checks++;
        if (v1 !== 11'd0) begin errors++; $display("FAIL async_reset1: got %h expected 0", v1); end
        @(negedge clk);
        rst   = 1'b0;
        moved = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (init_dp[0] || rd_en[0] || adv[0] || done[0] || fail[0]) moved = 1'b1;
        end
        checks++;
        if (moved) begin errors++; $display("FAIL reset_to_idle: got activity 1 expected 0"); end
    endtask

    initial begin
        test_reset();
        test_corridor();
        test_replay();
        test_backtrack();
        test_enclosed();
        test_overflow();
        test_ignore_start();
        test_done_priority();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
